// File: rtl/cmp_trend_tracker.sv
// Tracks the relation flags from a 4-bit magnitude comparator: saturating per-relation counters,
// a debounced trend FSM and a sticky illegal-flag error. Optional hold input via CMP_TRACK_HOLD_EN.
module cmp_trend_tracker #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CMP_TRACK_HOLD_EN
  input  logic             hold,
`endif
  input  logic             in_valid,
  input  logic             A_greaterthan_B,
  input  logic             A_equals_B,
  input  logic             A_lessthan_B,
  input  logic             clr_cnt,
  output logic [1:0]       state_o,
  output logic             changed,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    TR_NONE  = 2'b00,
    TR_ABOVE = 2'b01,
    TR_EQUAL = 2'b10,
    TR_BELOW = 2'b11
  } trend_e;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  trend_e     state_q, state_d;
  trend_e     cand_q, cand_d;
  logic [3:0] run_q, run_d, run_nxt;
  logic       changed_d;
  logic       legal;
  trend_e     rel;
  logic       freeze;

`ifdef CMP_TRACK_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    legal = 1'b0;
    rel   = TR_NONE;
    case ({A_greaterthan_B, A_equals_B, A_lessthan_B})
      3'b100:  begin legal = 1'b1; rel = TR_ABOVE; end
      3'b010:  begin legal = 1'b1; rel = TR_EQUAL; end
      3'b001:  begin legal = 1'b1; rel = TR_BELOW; end
      default: begin legal = 1'b0; rel = TR_NONE;  end
    endcase
  end

  // Trend FSM next state: an illegal sample or one matching the current trend aborts the run.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    run_d     = run_q;
    run_nxt   = 4'd0;
    changed_d = 1'b0;
    if (in_valid && !freeze) begin
      if (!legal || rel == state_q) begin
        run_d  = 4'd0;
        cand_d = TR_NONE;
      end else begin
        run_nxt = (rel == cand_q) ? run_q + 4'd1 : 4'd1;
        if (run_nxt == DEB) begin
          state_d   = rel;
          changed_d = 1'b1;
          run_d     = 4'd0;
          cand_d    = TR_NONE;
        end else begin
          run_d  = run_nxt;
          cand_d = rel;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TR_NONE;
      cand_q  <= TR_NONE;
      run_q   <= 4'd0;
      changed <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      changed <= changed_d;
    end
  end

  // Clear outranks a same-cycle sample for counters and err only.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      gt_cnt <= '0;
      eq_cnt <= '0;
      lt_cnt <= '0;
      err    <= 1'b0;
    end else if (in_valid) begin
      if (legal) begin
        case (rel)
          TR_ABOVE: gt_cnt <= sat_inc(gt_cnt);
          TR_EQUAL: eq_cnt <= sat_inc(eq_cnt);
          TR_BELOW: lt_cnt <= sat_inc(lt_cnt);
          default:  ;
        endcase
      end else begin
        err <= 1'b1;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_cmp_trend_tracker.sv
// Bench for cmp_trend_tracker: directed scenarios plus random traffic against a queue-based
// streak model; the hold scenario is compiled in when CMP_TRACK_HOLD_EN is defined.
module tb_cmp_trend_tracker;
  localparam int DEBOUNCE = 3;
  localparam int CNT_W    = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, in_valid, gt, eq, lt, clr_cnt, hold;
  logic [1:0]       state_o;
  logic             changed, err;
  logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;

  always #5 clk = ~clk;

  cmp_trend_tracker #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef CMP_TRACK_HOLD_EN
    .hold(hold),
`endif
    .in_valid(in_valid),
    .A_greaterthan_B(gt),
    .A_equals_B(eq),
    .A_lessthan_B(lt),
    .clr_cnt(clr_cnt),
    .state_o(state_o),
    .changed(changed),
    .gt_cnt(gt_cnt),
    .eq_cnt(eq_cnt),
    .lt_cnt(lt_cnt),
    .err(err)
  );

  int total = 0;
  int bad   = 0;
  string ph = "init";

  // Reference model: trend value, the current streak of agreeing relations, counts, error.
  int m_state, m_changed, m_gt, m_eq, m_lt, m_err;
  int streak[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", ph, tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, v, g, e, l, c, h);
    int rel;
    bit ok;
    ok  = (int'(g) + int'(e) + int'(l)) == 1;
    rel = g ? 1 : (e ? 2 : 3);
    m_changed = 0;
    if (r) begin
      m_state = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
      streak.delete();
      return;
    end
    if (c) begin
      m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
    end else if (v) begin
      if (!ok) m_err = 1;
      else if (rel == 1) m_gt = (m_gt < CMAX) ? m_gt + 1 : CMAX;
      else if (rel == 2) m_eq = (m_eq < CMAX) ? m_eq + 1 : CMAX;
      else m_lt = (m_lt < CMAX) ? m_lt + 1 : CMAX;
    end
    if (v && !h) begin
      if (!ok || rel == m_state) streak.delete();
      else begin
        if (streak.size() > 0 && streak[$] != rel) streak.delete();
        streak.push_back(rel);
        if (streak.size() == DEBOUNCE) begin
          m_state = rel;
          m_changed = 1;
          streak.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, v, g, e, l, c, h);
    rst = r; in_valid = v; gt = g; eq = e; lt = l; clr_cnt = c; hold = h;
    @(posedge clk);
    model(r, v, g, e, l, c, h);
    #1;
    chk("state", 32'(state_o), m_state);
    chk("changed", 32'(changed), m_changed);
    chk("gt_cnt", 32'(gt_cnt), m_gt);
    chk("eq_cnt", 32'(eq_cnt), m_eq);
    chk("lt_cnt", 32'(lt_cnt), m_lt);
    chk("err", 32'(err), m_err);
  endtask

  initial begin
    int cur, k, pat[6];
    logic [2:0] f;
    rst = 1'b1; in_valid = 0; gt = 0; eq = 0; lt = 0; clr_cnt = 0; hold = 0;

    ph = "reset";
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_err", 32'(err), 0);

    ph = "t1_gt";
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("no_early", 32'(state_o), 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("above", 32'(state_o), 1);
    chk("pulse", 32'(changed), 1);
    chk("gt3", 32'(gt_cnt), 3);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("pulse_end", 32'(changed), 0);

    ph = "t2_lt_eq";
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    chk("still_above", 32'(state_o), 1);
    step(0, 1, 0, 0, 1, 0, 0);
    chk("below", 32'(state_o), 3);
    chk("lt5", 32'(lt_cnt), 5);
    chk("eq1", 32'(eq_cnt), 1);

    ph = "t3_illegal";
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("run_broken", 32'(state_o), 3);
    chk("err_set", 32'(err), 1);
    step(0, 1, 0, 0, 1, 0, 0);
    chk("err_sticky", 32'(err), 1);

    ph = "t4_sat";
    for (int i = 0; i < 300; i++) step(0, 1, 0, 1, 0, 0, 0);
    chk("eq_sat", 32'(eq_cnt), CMAX);
    step(0, 1, 0, 1, 0, 1, 0);
    chk("eq_clr", 32'(eq_cnt), 0);
    chk("err_clr", 32'(err), 0);

    ph = "t5_gaps";
    step(1, 0, 0, 0, 0, 0, 0);
    pat = '{1, 0, 0, 1, 0, 1};
    foreach (pat[i]) step(0, pat[i][0], 0, 0, 1, 0, 0);
    chk("below_gap", 32'(state_o), 3);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_gt", 32'(gt_cnt), 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("run_discarded", 32'(state_o), 0);

`ifdef CMP_TRACK_HOLD_EN
    ph = "t6_hold";
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0, 1);
    chk("held", 32'(state_o), 0);
    chk("gt5", 32'(gt_cnt), 5);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
    chk("released", 32'(state_o), 1);
`endif

    ph = "random";
    cur = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cur = $urandom_range(1, 3);
      k = $urandom_range(0, 11);
      if (k == 0) f = 3'($urandom_range(0, 7));
      else f = (cur == 1) ? 3'b100 : (cur == 2) ? 3'b010 : 3'b001;
`ifdef CMP_TRACK_HOLD_EN
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, f[2], f[1], f[0],
           $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
`else
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, f[2], f[1], f[0],
           $urandom_range(0, 39) == 0, 1'b0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
